// File: rtl/ex_branch_resolve.sv
// Execute stage: latches the decoded instruction into MEM, computes the ALU result
// or branch target, keeps the zf/nf/cf flags and resolves branches for fetch.
module ex_branch_resolve #(
  parameter int W  = 16,
  parameter int AW = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         state,
  input  logic [W-1:0] ex_ir,
  input  logic [W-1:0] reg_A,
  input  logic [W-1:0] reg_B,
  output logic [W-1:0] mem_ir,
  output logic [W-1:0] reg_C,
  output logic [W-1:0] smdr,
  output logic         zf,
  output logic         nf,
  output logic         cf,
  output logic         br_taken
);

  localparam logic       EXEC  = 1'b1;
  localparam logic [4:0] NOP   = 5'b00000;
  localparam logic [4:0] HALT  = 5'b00001;
  localparam logic [4:0] LOAD  = 5'b00010;
  localparam logic [4:0] STORE = 5'b00011;
  localparam logic [4:0] SLL   = 5'b00100;
  localparam logic [4:0] SLA   = 5'b00101;
  localparam logic [4:0] SRL   = 5'b00110;
  localparam logic [4:0] SRA   = 5'b00111;
  localparam logic [4:0] ADD   = 5'b01000;
  localparam logic [4:0] ADDI  = 5'b01001;
  localparam logic [4:0] SUB   = 5'b01010;
  localparam logic [4:0] SUBI  = 5'b01011;
  localparam logic [4:0] CMP   = 5'b01100;
  localparam logic [4:0] AND   = 5'b01101;
  localparam logic [4:0] OR    = 5'b01110;
  localparam logic [4:0] XOR   = 5'b01111;
  localparam logic [4:0] LDIH  = 5'b10000;
  localparam logic [4:0] ADDC  = 5'b10001;
  localparam logic [4:0] SUBC  = 5'b10010;
  localparam logic [4:0] JUMP  = 5'b11000;
  localparam logic [4:0] JMPR  = 5'b11001;
  localparam logic [4:0] BZ    = 5'b11010;
  localparam logic [4:0] BNZ   = 5'b11011;
  localparam logic [4:0] BN    = 5'b11100;
  localparam logic [4:0] BNN   = 5'b11101;
  localparam logic [4:0] BC    = 5'b11110;
  localparam logic [4:0] BNC   = 5'b11111;

  logic [W-1:0] r_mem_ir, r_reg_C, r_smdr;
  logic         r_zf, r_nf, r_cf;

  logic [4:0]    w_ex_op, w_mem_op;
  logic [AW-1:0] w_imm;
  logic [3:0]    w_sh;
  logic [W-1:0]  w_imm_lo, w_imm_hi, w_sh_ext;
  logic [W:0]    w_res;
  logic          w_upd_c, w_upd_zn, w_upd_cf;
  logic          w_br_taken;
  logic          w_unused_ir;

  assign w_ex_op  = ex_ir[W-1:W-5];
  assign w_mem_op = r_mem_ir[W-1:W-5];
  assign w_imm    = ex_ir[AW-1:0];
  assign w_sh     = ex_ir[3:0];
  assign w_imm_lo = {{(W-AW){1'b0}}, w_imm};
  assign w_imm_hi = {w_imm, {(W-AW){1'b0}}};
  assign w_sh_ext = {{(W-4){1'b0}}, w_sh};
  assign w_unused_ir = &{1'b0, ex_ir[W-6:AW]};

  always_comb begin
    w_br_taken = 1'b0;
    case (w_mem_op)
      JUMP, JMPR: w_br_taken = 1'b1;
      BZ:         w_br_taken = r_zf;
      BNZ:        w_br_taken = ~r_zf;
      BN:         w_br_taken = r_nf;
      BNN:        w_br_taken = ~r_nf;
      BC:         w_br_taken = r_cf;
      BNC:        w_br_taken = ~r_cf;
      default:    w_br_taken = 1'b0;
    endcase
  end

  // Result is W+1 bits wide; the top bit is carry for adds and borrow for subtracts.
  always_comb begin
    w_res    = {1'b0, r_reg_C};
    w_upd_c  = 1'b1;
    w_upd_zn = 1'b0;
    w_upd_cf = 1'b0;
    case (w_ex_op)
      ADD: begin
        w_res = {1'b0, reg_A} + {1'b0, reg_B};
        w_upd_zn = 1'b1; w_upd_cf = 1'b1;
      end
      ADDC: begin
        w_res = {1'b0, reg_A} + {1'b0, reg_B} + {{W{1'b0}}, r_cf};
        w_upd_zn = 1'b1; w_upd_cf = 1'b1;
      end
      ADDI: begin
        w_res = {1'b0, reg_A} + {1'b0, w_imm_lo};
        w_upd_zn = 1'b1; w_upd_cf = 1'b1;
      end
      SUB, CMP: begin
        w_res = {1'b0, reg_A} - {1'b0, reg_B};
        w_upd_zn = 1'b1; w_upd_cf = 1'b1;
      end
      SUBC: begin
        w_res = {1'b0, reg_A} - {1'b0, reg_B} - {{W{1'b0}}, r_cf};
        w_upd_zn = 1'b1; w_upd_cf = 1'b1;
      end
      SUBI: begin
        w_res = {1'b0, reg_A} - {1'b0, w_imm_lo};
        w_upd_zn = 1'b1; w_upd_cf = 1'b1;
      end
      AND: begin w_res = {1'b0, reg_A & reg_B}; w_upd_zn = 1'b1; end
      OR:  begin w_res = {1'b0, reg_A | reg_B}; w_upd_zn = 1'b1; end
      XOR: begin w_res = {1'b0, reg_A ^ reg_B}; w_upd_zn = 1'b1; end
      SLL, SLA: begin w_res = {1'b0, reg_A << w_sh}; w_upd_zn = 1'b1; end
      SRL: begin w_res = {1'b0, reg_A >> w_sh}; w_upd_zn = 1'b1; end
      SRA: begin w_res = {1'b0, W'($signed(reg_A) >>> w_sh)}; w_upd_zn = 1'b1; end
      LDIH: begin w_res = {1'b0, reg_A} + {1'b0, w_imm_hi}; w_upd_zn = 1'b1; end
      LOAD, STORE: w_res = {1'b0, reg_A} + {1'b0, w_sh_ext};
      JUMP: w_res = {1'b0, w_imm_lo};
      JMPR, BZ, BNZ, BN, BNN, BC, BNC: w_res = {1'b0, reg_A} + {1'b0, w_imm_lo};
      NOP, HALT: w_upd_c = 1'b0;
      default:   w_upd_c = 1'b0;
    endcase
  end

  // A taken branch in MEM squashes whatever is in EX; only mem_ir changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_ir <= '0;
      r_reg_C  <= '0;
      r_smdr   <= '0;
      r_zf     <= 1'b0;
      r_nf     <= 1'b0;
      r_cf     <= 1'b0;
    end else if (state == EXEC) begin
      if (w_br_taken) begin
        r_mem_ir <= '0;
      end else begin
        r_mem_ir <= ex_ir;
        r_smdr   <= reg_B;
        if (w_upd_c)  r_reg_C <= w_res[W-1:0];
        if (w_upd_zn) begin
          r_zf <= (w_res[W-1:0] == '0);
          r_nf <= w_res[W-1];
        end
        if (w_upd_cf) r_cf <= w_res[W];
      end
    end
  end

  assign mem_ir   = r_mem_ir;
  assign reg_C    = r_reg_C;
  assign smdr     = r_smdr;
  assign zf       = r_zf;
  assign nf       = r_nf;
  assign cf       = r_cf;
  assign br_taken = w_br_taken;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed-vector bench for ex_branch_resolve: stimulus queues hand-computed
// expectations, a monitor pops and compares one entry after each clock edge.
module tb_ex_branch_resolve;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        state = 1'b0;
  logic [15:0] ex_ir = 16'h0;
  logic [15:0] reg_A = 16'h0;
  logic [15:0] reg_B = 16'h0;
  logic [15:0] mem_ir, reg_C, smdr;
  logic        zf, nf, cf, br_taken;

  ex_branch_resolve #(.W(16), .AW(8)) dut (
    .clock(clock), .reset(reset), .state(state),
    .ex_ir(ex_ir), .reg_A(reg_A), .reg_B(reg_B),
    .mem_ir(mem_ir), .reg_C(reg_C), .smdr(smdr),
    .zf(zf), .nf(nf), .cf(cf), .br_taken(br_taken)
  );

  always #5 clock = ~clock;

  localparam logic [4:0] OP_NOP = 5'b00000, OP_LOAD = 5'b00010, OP_SRL = 5'b00110,
                         OP_SRA = 5'b00111, OP_ADD = 5'b01000, OP_ADDI = 5'b01001,
                         OP_SUB = 5'b01010, OP_SUBI = 5'b01011, OP_CMP = 5'b01100,
                         OP_AND = 5'b01101, OP_XOR = 5'b01111, OP_LDIH = 5'b10000,
                         OP_ADDC = 5'b10001, OP_SUBC = 5'b10010, OP_JUMP = 5'b11000,
                         OP_JMPR = 5'b11001, OP_BZ = 5'b11010, OP_BNZ = 5'b11011,
                         OP_BN = 5'b11100, OP_BC = 5'b11110, OP_BNC = 5'b11111;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] c;
    logic [15:0] sd;
    logic [2:0]  f;   // {zf,nf,cf}
    logic        br;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [7:0] imm);
    return {op, 3'b000, imm};
  endfunction

  task automatic step(input logic st, input logic [15:0] ir, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] e_ir, input logic [15:0] e_c,
                      input logic [15:0] e_sd, input logic [2:0] e_f, input logic e_br);
    exp_t e;
    @(negedge clock);
    state = st; ex_ir = ir; reg_A = a; reg_B = b;
    e.ir = e_ir; e.c = e_c; e.sd = e_sd; e.f = e_f; e.br = e_br;
    q.push_back(e);
    @(posedge clock);
  endtask

  task automatic check_reset(input string name);
    n_vec++;
    if (mem_ir !== 16'h0 || reg_C !== 16'h0 || smdr !== 16'h0 ||
        {zf, nf, cf} !== 3'b000 || br_taken !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got ir=%h c=%h smdr=%h znc=%b br=%b, want all zero",
               name, mem_ir, reg_C, smdr, {zf, nf, cf}, br_taken);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (mem_ir !== e.ir || reg_C !== e.c || smdr !== e.sd ||
          {zf, nf, cf} !== e.f || br_taken !== e.br) begin
        n_err++;
        $display("FAIL vec%0d: got ir=%h c=%h smdr=%h znc=%b br=%b, want ir=%h c=%h smdr=%h znc=%b br=%b",
                 n_vec, mem_ir, reg_C, smdr, {zf, nf, cf}, br_taken,
                 e.ir, e.c, e.sd, e.f, e.br);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    check_reset("power_on_reset");
    reset = 1'b0;

    // JUMP into MEM, then async reset in the middle of the cycle
    step(1, mk(OP_JUMP, 8'h55), 16'h0000, 16'h0007, 16'hC055, 16'h0055, 16'h0007, 3'b000, 1);
    @(negedge clock);
    state = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset("async_reset_mid_cycle");
    #1 reset = 1'b0;

    // ADD wrap, then BZ taken, then squash
    step(1, mk(OP_ADD, 8'h00), 16'hFFFF, 16'h0001, 16'h4000, 16'h0000, 16'h0001, 3'b101, 0);
    step(1, mk(OP_BZ, 8'h20), 16'h0010, 16'h0002, 16'hD020, 16'h0030, 16'h0002, 3'b101, 1);
    step(1, mk(OP_ADD, 8'h00), 16'h0001, 16'h0001, 16'h0000, 16'h0030, 16'h0002, 3'b101, 0);
    // SUB borrow, AND keeps cf
    step(1, mk(OP_SUB, 8'h00), 16'h0003, 16'h0005, 16'h5000, 16'hFFFE, 16'h0005, 3'b011, 0);
    step(1, mk(OP_AND, 8'h00), 16'h0000, 16'h0000, 16'h6800, 16'h0000, 16'h0000, 3'b101, 0);
    // JUMP squashes following ADD
    step(1, mk(OP_JUMP, 8'h40), 16'h0009, 16'h0003, 16'hC040, 16'h0040, 16'h0003, 3'b101, 1);
    step(1, mk(OP_ADD, 8'h00), 16'h0001, 16'h0001, 16'h0000, 16'h0040, 16'h0003, 3'b101, 0);
    // stall three cycles with changing inputs
    step(0, mk(OP_ADD, 8'h00), 16'h1111, 16'h2222, 16'h0000, 16'h0040, 16'h0003, 3'b101, 0);
    step(0, mk(OP_SUB, 8'h00), 16'h3333, 16'h4444, 16'h0000, 16'h0040, 16'h0003, 3'b101, 0);
    step(0, mk(OP_JUMP, 8'h77), 16'h5555, 16'h6666, 16'h0000, 16'h0040, 16'h0003, 3'b101, 0);
    // resume
    step(1, mk(OP_ADDI, 8'h05), 16'h0010, 16'h0004, 16'h4805, 16'h0015, 16'h0004, 3'b000, 0);
    // BNZ not taken with zf=1, then LOAD enters normally
    step(1, mk(OP_SUB, 8'h00), 16'h0007, 16'h0007, 16'h5000, 16'h0000, 16'h0007, 3'b100, 0);
    step(1, mk(OP_BNZ, 8'h10), 16'h0100, 16'h0008, 16'hD810, 16'h0110, 16'h0008, 3'b100, 0);
    step(1, mk(OP_LOAD, 8'h04), 16'h0100, 16'hBEEF, 16'h1004, 16'h0104, 16'hBEEF, 3'b100, 0);
    // carry chain and borrow-in
    step(1, mk(OP_ADD, 8'h00), 16'h8000, 16'h8000, 16'h4000, 16'h0000, 16'h8000, 3'b101, 0);
    step(1, mk(OP_ADDC, 8'h00), 16'h0001, 16'h0002, 16'h8800, 16'h0004, 16'h0002, 3'b000, 0);
    step(1, mk(OP_SUBI, 8'h01), 16'h0000, 16'h0000, 16'h5801, 16'hFFFF, 16'h0000, 3'b011, 0);
    step(1, mk(OP_SUBC, 8'h00), 16'h0005, 16'h0002, 16'h9000, 16'h0002, 16'h0002, 3'b000, 0);
    // shifts
    step(1, mk(OP_SRA, 8'h04), 16'h8010, 16'h0000, 16'h3804, 16'hF801, 16'h0000, 3'b010, 0);
    step(1, mk(OP_SRL, 8'h04), 16'h8010, 16'h0000, 16'h3004, 16'h0801, 16'h0000, 3'b000, 0);
    // BN not taken, CMP, BC taken, squashed XOR
    step(1, mk(OP_BN, 8'h02), 16'h0005, 16'h0001, 16'hE002, 16'h0007, 16'h0001, 3'b000, 0);
    step(1, mk(OP_CMP, 8'h00), 16'h0001, 16'h0002, 16'h6000, 16'hFFFF, 16'h0002, 3'b011, 0);
    step(1, mk(OP_BC, 8'h08), 16'h0100, 16'h0000, 16'hF008, 16'h0108, 16'h0000, 3'b011, 1);
    step(1, mk(OP_XOR, 8'h00), 16'h00FF, 16'h00FF, 16'h0000, 16'h0108, 16'h0000, 3'b011, 0);
    // LDIH keeps cf, NOP holds reg_C
    step(1, mk(OP_LDIH, 8'h12), 16'h0034, 16'h0000, 16'h8012, 16'h1234, 16'h0000, 3'b001, 0);
    step(1, mk(OP_NOP, 8'h00), 16'h0005, 16'h0009, 16'h0000, 16'h1234, 16'h0009, 3'b001, 0);
    // JMPR then a back-to-back branch that must be squashed
    step(1, mk(OP_JMPR, 8'h03), 16'h0020, 16'h0000, 16'hC803, 16'h0023, 16'h0000, 3'b001, 1);
    step(1, mk(OP_BNC, 8'h01), 16'h0100, 16'h0005, 16'h0000, 16'h0023, 16'h0000, 3'b001, 0);

    @(negedge clock);
    state = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations still queued, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
